// File: rtl/bullet_ctrl_if.sv
// Bullet controller signal bundle.
// master drives player/video/collision inputs, slave is the controller.
interface bullet_ctrl_if;
   logic       frameTick;
   logic       fire;
   logic [9:0] shooterPosX;
   logic [9:0] shooterPosY;
   logic       collision;
   logic [9:0] horCnt;
   logic [9:0] verCnt;
   logic [9:0] bulletPosX;
   logic [9:0] bulletPosY;
   logic       bulletActive;
   logic       hitPulse;
   logic [5:0] rgbContent;

   modport master (
      output frameTick, fire, shooterPosX, shooterPosY,
      output collision, horCnt, verCnt,
      input  bulletPosX, bulletPosY, bulletActive,
      input  hitPulse, rgbContent
   );

   modport slave (
      input  frameTick, fire, shooterPosX, shooterPosY,
      input  collision, horCnt, verCnt,
      output bulletPosX, bulletPosY, bulletActive,
      output hitPulse, rgbContent
   );
endinterface

// File: rtl/bullet_ctrl.sv
// Player bullet controller: launch, per-frame climb, hit/miss retire, cooldown.
// Define BULLET_RENDER_EN to also produce the registered bullet pixel colour.
module bullet_ctrl #(
   parameter int         SPEED           = 4,
   parameter int         TOP_LIMIT       = 10,
   parameter int         LAUNCH_OFS      = 8,
   parameter int         COOLDOWN_FRAMES = 8,
   parameter logic [9:0] PARK            = 10'd1023,
   parameter int         BULLET_W        = 2,
   parameter int         BULLET_H        = 4,
   parameter logic [5:0] COLOR           = 6'b111111
) (
   input logic         clk,
   input logic         reset,
   bullet_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FLYING, HIT, COOLDOWN} state_t;

   localparam int          CD_LAST   = (COOLDOWN_FRAMES < 1) ? 0 : COOLDOWN_FRAMES - 1;
   localparam logic [15:0] CD_LAST_V = 16'(CD_LAST);
   localparam logic [9:0]  SPEED_V   = 10'(SPEED);
   localparam logic [9:0]  OFS_V     = 10'(LAUNCH_OFS);
   localparam logic [10:0] RETIRE_Y  = 11'(TOP_LIMIT + SPEED);

   state_t      state;
   logic [15:0] cdCnt;
   logic [9:0]  launchY;
   logic        retire;

   // Launch height clamps at the top edge instead of wrapping.
   always_comb begin
      launchY = (bus.shooterPosY < OFS_V) ? 10'd0 : bus.shooterPosY - OFS_V;
      retire  = ({1'b0, bus.bulletPosY} <= RETIRE_Y);
   end

   // Bullet state machine with registered position and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         cdCnt            <= '0;
         bus.bulletPosX   <= PARK;
         bus.bulletPosY   <= PARK;
         bus.bulletActive <= 1'b0;
         bus.hitPulse     <= 1'b0;
      end else begin
         bus.hitPulse <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.frameTick && bus.fire) begin
                  bus.bulletPosX   <= bus.shooterPosX;
                  bus.bulletPosY   <= launchY;
                  bus.bulletActive <= 1'b1;
                  state            <= FLYING;
               end
            end
            FLYING: begin
               if (bus.collision) begin
                  bus.bulletPosX   <= PARK;
                  bus.bulletPosY   <= PARK;
                  bus.bulletActive <= 1'b0;
                  bus.hitPulse     <= 1'b1;
                  state            <= HIT;
               end else if (bus.frameTick) begin
                  if (retire) begin
                     bus.bulletPosX   <= PARK;
                     bus.bulletPosY   <= PARK;
                     bus.bulletActive <= 1'b0;
                     cdCnt            <= '0;
                     state            <= COOLDOWN;
                  end else begin
                     bus.bulletPosY <= bus.bulletPosY - SPEED_V;
                  end
               end
            end
            HIT: begin
               if (bus.frameTick) begin
                  cdCnt <= '0;
                  state <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               if (bus.frameTick) begin
                  if (cdCnt == CD_LAST_V) begin
                     state <= IDLE;
                  end else begin
                     cdCnt <= cdCnt + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BULLET_RENDER_EN
   localparam logic [10:0] BW_V = 11'(BULLET_W);
   localparam logic [10:0] BH_V = 11'(BULLET_H);

   logic [10:0] hx;
   logic [10:0] vy;
   logic [10:0] bx;
   logic [10:0] by;
   logic        onBullet;

   // Widened compares; the left edge is rearranged so small X never wraps.
   always_comb begin
      hx       = {1'b0, bus.horCnt};
      vy       = {1'b0, bus.verCnt};
      bx       = {1'b0, bus.bulletPosX};
      by       = {1'b0, bus.bulletPosY};
      onBullet = bus.bulletActive
               && (hx + BW_V > bx) && (hx < bx + BW_V)
               && (vy >= by) && (vy < by + BH_V);
   end

   // Pixel colour, one cycle behind the scan counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rgbContent <= 6'b000000;
      end else begin
         bus.rgbContent <= onBullet ? COLOR : 6'b000000;
      end
   end
`else
   logic unusedRender;

   assign bus.rgbContent = 6'b000000;
   assign unusedRender   = ^{bus.horCnt, bus.verCnt};
`endif

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them.
module tb_bullet_ctrl;
   localparam logic [9:0] PK = 10'd1023;
`ifdef BULLET_RENDER_EN
   localparam logic [5:0] RGB_ON = 6'b111111;
`else
   localparam logic [5:0] RGB_ON = 6'b000000;
`endif

   typedef struct packed {
      int         due;
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       hit;
      logic [5:0] rgb;
      logic       chkRgb;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   bullet_ctrl_if bus();

   bullet_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t  expQ[$];
   string nameQ[$];
   int    cyc    = 0;
   int    vecCnt = 0;
   int    errCnt = 0;
   exp_t  e;
   string n;
   logic  ok;

   // Cycle stamp advances on the active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation that has come due.
   always @(negedge clk) begin
      while (expQ.size() > 0 && expQ[0].due <= cyc) begin
         e = expQ.pop_front();
         n = nameQ.pop_front();
         vecCnt++;
         ok = (bus.bulletPosX === e.x) && (bus.bulletPosY === e.y)
           && (bus.bulletActive === e.act) && (bus.hitPulse === e.hit)
           && (!e.chkRgb || bus.rgbContent === e.rgb)
           && (e.due == cyc);
         if (!ok) begin
            errCnt++;
            $display("FAIL %s: got x=%0d y=%0d act=%b hit=%b rgb=%b, want x=%0d y=%0d act=%b hit=%b rgb=%b",
                     n, bus.bulletPosX, bus.bulletPosY, bus.bulletActive,
                     bus.hitPulse, bus.rgbContent, e.x, e.y, e.act, e.hit, e.rgb);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Expectation for the outputs right after the next active edge.
   task automatic pushExp(input string nm, input logic [9:0] x,
                          input logic [9:0] y, input logic act,
                          input logic hit, input logic [5:0] rgb = 6'd0,
                          input logic chkRgb = 1'b0);
      exp_t t;
      t.due    = cyc + 1;
      t.x      = x;
      t.y      = y;
      t.act    = act;
      t.hit    = hit;
      t.rgb    = rgb;
      t.chkRgb = chkRgb;
      expQ.push_back(t);
      nameQ.push_back(nm);
   endtask

   initial begin
      reset           = 1'b1;
      bus.frameTick   = 1'b0;
      bus.fire        = 1'b0;
      bus.shooterPosX = '0;
      bus.shooterPosY = '0;
      bus.collision   = 1'b0;
      bus.horCnt      = '0;
      bus.verCnt      = '0;
      tick();
      tick();
      pushExp("reset", PK, PK, 1'b0, 1'b0, 6'd0, 1'b1);
      tick();
      reset = 1'b0;

      // Launch and climb.
      bus.fire        = 1'b1;
      bus.shooterPosX = 10'd320;
      bus.shooterPosY = 10'd440;
      pushExp("fireNoTick", PK, PK, 1'b0, 1'b0);
      tick();
      bus.frameTick = 1'b1;
      pushExp("launch", 10'd320, 10'd432, 1'b1, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      bus.fire      = 1'b0;
      pushExp("holdNoTick", 10'd320, 10'd432, 1'b1, 1'b0);
      tick();
      repeat (3) begin
         bus.frameTick = 1'b1;
         tick();
         bus.frameTick = 1'b0;
         tick();
      end
      pushExp("fly3", 10'd320, 10'd420, 1'b1, 1'b0);
      tick();
      reset = 1'b1;
      pushExp("rstFly", PK, PK, 1'b0, 1'b0);
      tick();
      reset = 1'b0;

      // Miss at the top, then full cooldown with fire held.
      bus.shooterPosX = 10'd200;
      bus.shooterPosY = 10'd38;
      bus.fire        = 1'b1;
      bus.frameTick   = 1'b1;
      pushExp("launch30", 10'd200, 10'd30, 1'b1, 1'b0);
      tick();
      bus.fire = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         bus.frameTick = 1'b1;
         pushExp("climb", 10'd200, 10'(30 - 4 * i), 1'b1, 1'b0);
         tick();
         bus.frameTick = 1'b0;
         tick();
      end
      bus.fire      = 1'b1;
      bus.frameTick = 1'b1;
      pushExp("miss", PK, PK, 1'b0, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      tick();
      for (int i = 1; i <= 8; i++) begin
         bus.frameTick = 1'b1;
         pushExp("cool", PK, PK, 1'b0, 1'b0);
         tick();
         bus.frameTick = 1'b0;
         pushExp("coolGap", PK, PK, 1'b0, 1'b0);
         tick();
      end
      bus.frameTick = 1'b1;
      pushExp("relaunch", 10'd200, 10'd30, 1'b1, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      bus.fire      = 1'b0;

      // Single-cycle collision mid-flight.
      reset = 1'b1;
      tick();
      reset           = 1'b0;
      bus.shooterPosX = 10'd300;
      bus.shooterPosY = 10'd208;
      bus.fire        = 1'b1;
      bus.frameTick   = 1'b1;
      pushExp("launch200", 10'd300, 10'd200, 1'b1, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      bus.fire      = 1'b0;
      bus.collision = 1'b1;
      pushExp("hit", PK, PK, 1'b0, 1'b1);
      tick();
      bus.collision = 1'b0;
      bus.fire      = 1'b1;
      pushExp("hitOnce", PK, PK, 1'b0, 1'b0);
      tick();
      pushExp("hitHold", PK, PK, 1'b0, 1'b0);
      tick();
      bus.frameTick = 1'b1;
      pushExp("hitToCool", PK, PK, 1'b0, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      tick();
      for (int i = 1; i <= 8; i++) begin
         bus.frameTick = 1'b1;
         pushExp("cool2", PK, PK, 1'b0, 1'b0);
         tick();
         bus.frameTick = 1'b0;
         tick();
      end
      bus.frameTick = 1'b1;
      pushExp("relaunch2", 10'd300, 10'd200, 1'b1, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      bus.fire      = 1'b0;

      // Collision and frameTick together: hit wins, no move.
      pushExp("at200", 10'd300, 10'd200, 1'b1, 1'b0);
      tick();
      bus.collision = 1'b1;
      bus.frameTick = 1'b1;
      pushExp("hitTick", PK, PK, 1'b0, 1'b1);
      tick();
      bus.collision = 1'b0;
      bus.frameTick = 1'b0;
      pushExp("hitTickEnd", PK, PK, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      pushExp("rstHit", PK, PK, 1'b0, 1'b0);
      tick();
      reset = 1'b0;

      // Clamped launch, immediate miss, reset mid-cooldown.
      bus.shooterPosX = 10'd50;
      bus.shooterPosY = 10'd5;
      bus.fire        = 1'b1;
      bus.frameTick   = 1'b1;
      pushExp("clampLaunch", 10'd50, 10'd0, 1'b1, 1'b0);
      tick();
      bus.fire = 1'b0;
      pushExp("clampMiss", PK, PK, 1'b0, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      tick();
      bus.frameTick = 1'b1;
      pushExp("clampCool", PK, PK, 1'b0, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      reset         = 1'b1;
      pushExp("rstCool", PK, PK, 1'b0, 1'b0);
      tick();
      reset         = 1'b0;
      bus.fire      = 1'b1;
      bus.frameTick = 1'b1;
      pushExp("afterRst", 10'd50, 10'd0, 1'b1, 1'b0);
      tick();
      bus.frameTick = 1'b0;
      bus.fire      = 1'b0;

      // Pixel window around a bullet at (100,50).
      reset = 1'b1;
      tick();
      reset           = 1'b0;
      bus.shooterPosX = 10'd100;
      bus.shooterPosY = 10'd58;
      bus.fire        = 1'b1;
      bus.frameTick   = 1'b1;
      pushExp("launchPix", 10'd100, 10'd50, 1'b1, 1'b0);
      tick();
      bus.fire      = 1'b0;
      bus.frameTick = 1'b0;
      bus.horCnt    = 10'd101;
      bus.verCnt    = 10'd52;
      pushExp("rgbOn", 10'd100, 10'd50, 1'b1, 1'b0, RGB_ON, 1'b1);
      tick();
      bus.horCnt = 10'd102;
      pushExp("rgbRight", 10'd100, 10'd50, 1'b1, 1'b0, 6'd0, 1'b1);
      tick();
      bus.horCnt = 10'd99;
      bus.verCnt = 10'd50;
      pushExp("rgbLeftIn", 10'd100, 10'd50, 1'b1, 1'b0, RGB_ON, 1'b1);
      tick();
      bus.horCnt = 10'd98;
      pushExp("rgbLeftOut", 10'd100, 10'd50, 1'b1, 1'b0, 6'd0, 1'b1);
      tick();
      bus.horCnt = 10'd100;
      bus.verCnt = 10'd54;
      pushExp("rgbBelow", 10'd100, 10'd50, 1'b1, 1'b0, 6'd0, 1'b1);
      tick();
      bus.verCnt = 10'd49;
      pushExp("rgbAbove", 10'd100, 10'd50, 1'b1, 1'b0, 6'd0, 1'b1);
      tick();

      for (int i = 0; i < 10 && expQ.size() > 0; i++) tick();
      if (expQ.size() > 0) begin
         $display("FAIL drain: %0d expectations never checked, want 0", expQ.size());
         errCnt += expQ.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end
endmodule
